// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit: tracks in-flight register writes per {bank, addr} and stalls
// R-stage issue on RAW/WAW, forwarding from writeback when the producer lands this cycle.
module scoreboard_hazard_unit #(
  parameter int TotalNumBank = 8,
  parameter int AddrWidth    = 5,
  parameter int NumReadPorts = 3,
  parameter int NumUntracked = 4,
  parameter int StallLimit   = 64
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       issue_valid_r,
  input  logic [NumReadPorts*TotalNumBank-1:0]       readEn_r,
  input  logic [NumReadPorts*AddrWidth-1:0]          readAddr_r,
  input  logic [TotalNumBank-1:0]                    writeEn_r,
  input  logic [AddrWidth-1:0]                       writeAddr_r,
  input  logic [TotalNumBank-1:0]                    writeEn_w,
  input  logic [AddrWidth-1:0]                       writeAddr_w,
  input  logic                                       clear_all,
  output logic                                       stall_f,
  output logic                                       stall_d,
  output logic                                       stall_r,
  output logic                                       flush_e,
  output logic [NumReadPorts-1:0]                    fwd,
  output logic [AddrWidth+$clog2(TotalNumBank):0]    pending_cnt,
  output logic                                       hazard_timeout,
  output logic                                       err_multihot
);

  localparam int BankW      = $clog2(TotalNumBank);
  localparam int EntW       = BankW + AddrWidth;
  localparam int NumEntries = TotalNumBank << AddrWidth;
  localparam int CntW       = EntW + 1;
  localparam int StallW     = $clog2(StallLimit + 1);
  localparam logic [TotalNumBank-1:0] BankOne = 1;

  function automatic logic is_multihot(input logic [TotalNumBank-1:0] sel);
    return (sel & (sel - BankOne)) != '0;
  endfunction

  function automatic logic is_onehot(input logic [TotalNumBank-1:0] sel);
    return (sel != '0) && !is_multihot(sel);
  endfunction

  function automatic logic [BankW-1:0] onehot2bin(input logic [TotalNumBank-1:0] sel);
    logic [BankW-1:0] b;
    b = '0;
    for (int k = 0; k < TotalNumBank; k++) begin
      if (sel[k]) b = BankW'(k);
    end
    return b;
  endfunction

  // Multi-hot selects fail the one-hot test, so they drop out as untracked here.
  function automatic logic is_tracked(input logic [TotalNumBank-1:0] sel,
                                      input logic [AddrWidth-1:0]    addr);
    return is_onehot(sel) && (addr != '0) && (int'(onehot2bin(sel)) >= NumUntracked);
  endfunction

  logic [NumEntries-1:0] pending_q, pending_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [StallW-1:0]     stall_cnt_q, stall_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  err_q, err_d;

  logic                    wb_valid;
  logic [EntW-1:0]         wb_e;
  logic                    wb_clr;
  logic                    dst_trk;
  logic [EntW-1:0]         dst_e;
  logic                    waw;
  logic                    raw_any;
  logic                    rd_multihot;
  logic                    stall;
  logic                    issue_fire;
  logic                    multihot_seen;
  logic [NumReadPorts-1:0] src_trk;
  logic [NumReadPorts-1:0] fwd_c;
  logic [EntW-1:0]         src_e [NumReadPorts];
  logic [TotalNumBank-1:0] src_sel [NumReadPorts];
  logic [AddrWidth-1:0]    src_addr [NumReadPorts];

  always_comb begin
    wb_valid    = is_onehot(writeEn_w);
    wb_e        = {onehot2bin(writeEn_w), writeAddr_w};
    dst_trk     = is_tracked(writeEn_r, writeAddr_r);
    dst_e       = {onehot2bin(writeEn_r), writeAddr_r};
    waw         = dst_trk && pending_q[dst_e] && !(wb_valid && (wb_e == dst_e));
    raw_any     = 1'b0;
    rd_multihot = 1'b0;
    fwd_c       = '0;
    src_trk     = '0;
    for (int i = 0; i < NumReadPorts; i++) begin
      src_sel[i]  = readEn_r[i*TotalNumBank +: TotalNumBank];
      src_addr[i] = readAddr_r[i*AddrWidth +: AddrWidth];
      src_e[i]    = {onehot2bin(src_sel[i]), src_addr[i]};
      src_trk[i]  = is_tracked(src_sel[i], src_addr[i]);
      rd_multihot = rd_multihot | is_multihot(src_sel[i]);
      if (src_trk[i] && pending_q[src_e[i]]) begin
        if (wb_valid && (wb_e == src_e[i])) fwd_c[i] = 1'b1;
        else                                raw_any  = 1'b1;
      end
    end
    stall         = issue_valid_r && (raw_any || waw);
    issue_fire    = issue_valid_r && !stall && dst_trk;
    wb_clr        = wb_valid && pending_q[wb_e];
    multihot_seen = is_multihot(writeEn_w) ||
                    (issue_valid_r && (rd_multihot || is_multihot(writeEn_r)));
  end

  // Clear is applied before set so a new producer keeps ownership of a recycled entry.
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    if (clear_all) begin
      pending_d = '0;
      cnt_d     = '0;
    end else begin
      if (wb_clr)     pending_d[wb_e]  = 1'b0;
      if (issue_fire) pending_d[dst_e] = 1'b1;
      if (issue_fire && !wb_clr)      cnt_d = cnt_q + CntW'(1);
      else if (wb_clr && !issue_fire) cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    stall_cnt_d = '0;
    if (stall) begin
      if (stall_cnt_q == StallW'(StallLimit)) stall_cnt_d = stall_cnt_q;
      else                                    stall_cnt_d = stall_cnt_q + StallW'(1);
    end
    timeout_d = timeout_q || (stall_cnt_d == StallW'(StallLimit));
    err_d     = err_q || multihot_seen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  assign stall_f        = stall;
  assign stall_d        = stall;
  assign stall_r        = stall;
  assign flush_e        = stall;
  assign fwd            = fwd_c;
  assign pending_cnt    = cnt_q;
  assign hazard_timeout = timeout_q;
  assign err_multihot   = err_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit: directed scenarios plus randomized traffic
// compared against a per-entry pending-set model.
module tb_scoreboard_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid_r;
  logic [23:0] readEn_r;
  logic [14:0] readAddr_r;
  logic [7:0]  writeEn_r;
  logic [4:0]  writeAddr_r;
  logic [7:0]  writeEn_w;
  logic [4:0]  writeAddr_w;
  logic        clear_all;
  logic        stall_f, stall_d, stall_r, flush_e;
  logic [2:0]  fwd;
  logic [8:0]  pending_cnt;
  logic        hazard_timeout, err_multihot;

  int n_tests = 0;
  int n_fail  = 0;

  bit pend [256];
  int run;
  bit m_tout, m_err;

  scoreboard_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .issue_valid_r(issue_valid_r),
    .readEn_r(readEn_r), .readAddr_r(readAddr_r),
    .writeEn_r(writeEn_r), .writeAddr_r(writeAddr_r),
    .writeEn_w(writeEn_w), .writeAddr_w(writeAddr_w),
    .clear_all(clear_all),
    .stall_f(stall_f), .stall_d(stall_d), .stall_r(stall_r), .flush_e(flush_e),
    .fwd(fwd), .pending_cnt(pending_cnt),
    .hazard_timeout(hazard_timeout), .err_multihot(err_multihot)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int bank_of(logic [7:0] s);
    int b = -1;
    for (int k = 0; k < 8; k++) if (s[k]) b = k;
    return b;
  endfunction

  function automatic bit m_tracked(logic [7:0] s, logic [4:0] a);
    return ($countones(s) == 1) && (a != 0) && (bank_of(s) >= 4);
  endfunction

  function automatic int ent(logic [7:0] s, logic [4:0] a);
    return bank_of(s) * 32 + int'(a);
  endfunction

  function automatic bit wb_hits(int e);
    return ($countones(writeEn_w) == 1) && (ent(writeEn_w, writeAddr_w) == e);
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int k = 0; k < 256; k++) c += int'(pend[k]);
    return c;
  endfunction

  function automatic logic [2:0] m_fwd();
    logic [2:0] f = '0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] s;
      logic [4:0] a;
      s = readEn_r[i*8 +: 8];
      a = readAddr_r[i*5 +: 5];
      if (m_tracked(s, a) && pend[ent(s, a)] && wb_hits(ent(s, a))) f[i] = 1'b1;
    end
    return f;
  endfunction

  function automatic bit m_stall();
    bit hz = 0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] s;
      logic [4:0] a;
      s = readEn_r[i*8 +: 8];
      a = readAddr_r[i*5 +: 5];
      if (m_tracked(s, a) && pend[ent(s, a)] && !wb_hits(ent(s, a))) hz = 1;
    end
    if (m_tracked(writeEn_r, writeAddr_r) && pend[ent(writeEn_r, writeAddr_r)] &&
        !wb_hits(ent(writeEn_r, writeAddr_r))) hz = 1;
    return issue_valid_r && hz;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 256; k++) pend[k] = 0;
    run = 0; m_tout = 0; m_err = 0;
  endtask

  // Advance one clock, then apply the same cycle's effects to the model.
  task automatic tick();
    bit st, fire, clr, mh;
    int de, we;
    st   = m_stall();
    fire = issue_valid_r && !st && m_tracked(writeEn_r, writeAddr_r);
    de   = fire ? ent(writeEn_r, writeAddr_r) : 0;
    clr  = ($countones(writeEn_w) == 1) && pend[ent(writeEn_w, writeAddr_w)];
    we   = clr ? ent(writeEn_w, writeAddr_w) : 0;
    mh   = ($countones(writeEn_w) > 1) ||
           (issue_valid_r && (($countones(writeEn_r) > 1) || ($countones(readEn_r[7:0]) > 1) ||
                              ($countones(readEn_r[15:8]) > 1) || ($countones(readEn_r[23:16]) > 1)));
    @(posedge clk);
    #1;
    if (clear_all) begin
      for (int k = 0; k < 256; k++) pend[k] = 0;
    end else begin
      if (clr)  pend[we] = 0;
      if (fire) pend[de] = 1;
    end
    run = st ? ((run < 64) ? run + 1 : 64) : 0;
    if (run == 64) m_tout = 1;
    if (mh) m_err = 1;
  endtask

  task automatic idle();
    issue_valid_r = 0; readEn_r = '0; readAddr_r = '0;
    writeEn_r = '0; writeAddr_r = '0; writeEn_w = '0; writeAddr_w = '0;
    clear_all = 0;
  endtask

  task automatic set_src(int i, logic [7:0] s, logic [4:0] a);
    readEn_r[i*8 +: 8]   = s;
    readAddr_r[i*5 +: 5] = a;
  endtask

  task automatic do_issue(logic [7:0] s, logic [4:0] a);
    idle();
    issue_valid_r = 1; writeEn_r = s; writeAddr_r = a;
    tick();
    idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    #12;
    n_tests++;
    if (pending_cnt !== 9'd0 || stall_r !== 1'b0 || fwd !== 3'b000 ||
        hazard_timeout !== 1'b0 || err_multihot !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: cnt=%0d stall=%b fwd=%b tout=%b err=%b, expected all 0",
               pending_cnt, stall_r, fwd, hazard_timeout, err_multihot);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_raw_fwd();
    do_issue(8'h10, 5'd3);
    n_tests++;
    if (pending_cnt !== 9'(m_cnt())) begin
      n_fail++; $display("FAIL issue_cnt: got %0d expected %0d", pending_cnt, m_cnt());
    end
    issue_valid_r = 1; set_src(0, 8'h10, 5'd3);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if ({stall_f, stall_d, stall_r, flush_e} !== {4{m_stall()}}) begin
        n_fail++; $display("FAIL raw_stall: got %b expected %b", {stall_f, stall_d, stall_r, flush_e}, {4{m_stall()}});
      end
      tick();
    end
    writeEn_w = 8'h10; writeAddr_w = 5'd3;
    #1;
    n_tests++;
    if (fwd !== m_fwd() || stall_r !== m_stall()) begin
      n_fail++; $display("FAIL wb_forward: fwd=%b stall=%b expected fwd=%b stall=%b", fwd, stall_r, m_fwd(), m_stall());
    end
    tick();
    idle();
    n_tests++;
    if (pending_cnt !== 9'(m_cnt())) begin
      n_fail++; $display("FAIL wb_clear_cnt: got %0d expected %0d", pending_cnt, m_cnt());
    end
  endtask

  task automatic test_untracked();
    do_issue(8'h20, 5'd7);
    do_issue(8'h80, 5'd1);
    issue_valid_r = 1;
    set_src(0, 8'h20, 5'd0); set_src(1, 8'h01, 5'd7); set_src(2, 8'h08, 5'd7);
    writeEn_r = 8'h40; writeAddr_r = 5'd0;
    writeEn_w = 8'h01; writeAddr_w = 5'd7;
    #1;
    n_tests++;
    if (stall_r !== m_stall() || fwd !== m_fwd()) begin
      n_fail++; $display("FAIL untracked_reads: stall=%b fwd=%b expected stall=%b fwd=%b", stall_r, fwd, m_stall(), m_fwd());
    end
    tick();
    idle();
    n_tests++;
    if (pending_cnt !== 9'(m_cnt())) begin
      n_fail++; $display("FAIL untracked_cnt: got %0d expected %0d", pending_cnt, m_cnt());
    end
  endtask

  task automatic test_set_wins();
    issue_valid_r = 1; writeEn_r = 8'h20; writeAddr_r = 5'd7;
    writeEn_w = 8'h20; writeAddr_w = 5'd7;
    #1;
    n_tests++;
    if (stall_r !== m_stall()) begin
      n_fail++; $display("FAIL set_wins_stall: got %b expected %b", stall_r, m_stall());
    end
    tick();
    idle();
    n_tests++;
    if (pending_cnt !== 9'(m_cnt())) begin
      n_fail++; $display("FAIL set_wins_cnt: got %0d expected %0d", pending_cnt, m_cnt());
    end
    issue_valid_r = 1; set_src(1, 8'h20, 5'd7);
    #1;
    n_tests++;
    if (stall_r !== m_stall()) begin
      n_fail++; $display("FAIL set_wins_pending: stall=%b expected %b", stall_r, m_stall());
    end
    idle();
  endtask

  task automatic test_timeout();
    issue_valid_r = 1; set_src(2, 8'h80, 5'd1);
    repeat (63) tick();
    n_tests++;
    if (hazard_timeout !== m_tout) begin
      n_fail++; $display("FAIL timeout_early: got %b expected %b", hazard_timeout, m_tout);
    end
    tick();
    n_tests++;
    if (hazard_timeout !== m_tout) begin
      n_fail++; $display("FAIL timeout_limit: got %b expected %b", hazard_timeout, m_tout);
    end
    idle();
    tick(); tick();
    n_tests++;
    if (hazard_timeout !== m_tout || stall_r !== m_stall()) begin
      n_fail++; $display("FAIL timeout_sticky: tout=%b stall=%b expected tout=%b stall=%b", hazard_timeout, stall_r, m_tout, m_stall());
    end
  endtask

  task automatic test_clear_all();
    do_issue(8'h40, 5'd9);
    issue_valid_r = 1; writeEn_r = 8'h40; writeAddr_r = 5'd10;
    writeEn_w = 8'h80; writeAddr_w = 5'd1;
    clear_all = 1;
    tick();
    idle();
    n_tests++;
    if (pending_cnt !== 9'(m_cnt()) || hazard_timeout !== m_tout) begin
      n_fail++; $display("FAIL clear_all: cnt=%0d tout=%b expected cnt=%0d tout=%b", pending_cnt, hazard_timeout, m_cnt(), m_tout);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_issue(8'h20, 5'd7); do_issue(8'h80, 5'd1); do_issue(8'h40, 5'd2);
    do_issue(8'h40, 5'd3); do_issue(8'h10, 5'd9);
    n_tests++;
    if (pending_cnt !== 9'(m_cnt())) begin
      n_fail++; $display("FAIL five_pending: got %0d expected %0d", pending_cnt, m_cnt());
    end
    issue_valid_r = 1; set_src(0, 8'h40, 5'd2);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_tests++;
    if (pending_cnt !== 9'd0 || stall_r !== m_stall() || flush_e !== m_stall() || hazard_timeout !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: cnt=%0d stall=%b flush=%b tout=%b expected 0", pending_cnt, stall_r, flush_e, hazard_timeout);
    end
    @(negedge clk);
    rst_n = 1;
    idle();
    issue_valid_r = 1; set_src(0, 8'h30, 5'd5);
    #1;
    n_tests++;
    if (stall_r !== m_stall() || err_multihot !== 1'b0) begin
      n_fail++; $display("FAIL multihot_pre: stall=%b err=%b expected stall=%b err=0", stall_r, err_multihot, m_stall());
    end
    tick();
    idle();
    n_tests++;
    if (err_multihot !== m_err) begin
      n_fail++; $display("FAIL multihot_flag: got %b expected %b", err_multihot, m_err);
    end
  endtask

  function automatic logic [7:0] rand_sel();
    int r = $urandom_range(0, 63);
    if (r < 10) return 8'h00;
    if (r < 52) return 8'h10 << (r % 4);
    if (r < 62) return 8'h01 << (r % 4);
    return 8'h30 << (r % 2);
  endfunction

  task automatic test_random();
    int pick;
    for (int c = 0; c < 500; c++) begin
      idle();
      issue_valid_r = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) set_src(i, rand_sel(), 5'($urandom_range(0, 3)));
      writeEn_r = rand_sel(); writeAddr_r = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, 255);
        for (int k = 0; k < 256; k++) if (pend[(pick + k) % 256]) begin
          pick = (pick + k) % 256; break;
        end
        writeEn_w = 8'h01 << (pick / 32); writeAddr_w = 5'(pick % 32);
      end else begin
        writeEn_w = rand_sel(); writeAddr_w = 5'($urandom_range(0, 3));
      end
      clear_all = ($urandom_range(0, 39) == 0);
      #1;
      n_tests++;
      if ({stall_f, stall_d, stall_r, flush_e} !== {4{m_stall()}} || fwd !== m_fwd()) begin
        n_fail++; $display("FAIL rand_comb[%0d]: stall=%b fwd=%b expected stall=%b fwd=%b", c,
                           {stall_f, stall_d, stall_r, flush_e}, fwd, {4{m_stall()}}, m_fwd());
      end
      tick();
      n_tests++;
      if (pending_cnt !== 9'(m_cnt()) || hazard_timeout !== m_tout || err_multihot !== m_err) begin
        n_fail++; $display("FAIL rand_state[%0d]: cnt=%0d tout=%b err=%b expected cnt=%0d tout=%b err=%b", c,
                           pending_cnt, hazard_timeout, err_multihot, m_cnt(), m_tout, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw_fwd();
    test_untracked();
    test_set_wins();
    test_timeout();
    test_clear_all();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
